reorder_buffer: RTL and testbench

In-order commit buffer for the backend. It allocates one entry per dispatched instruction, records out-of-order results from the functional units, and retires up to RETIRE_WIDTH completed entries per cycle in program order. Retirement drives the rob modport of the arch_reg_file_reorder_buffer_if array, which writes the architectural register file.

---
 rtl/reorder_buffer_pkg.sv | 24 ++
 rtl/arch_reg_file_reorder_buffer_if.sv | 12 +
 rtl/rob_retire_select.sv | 25 ++
 rtl/reorder_buffer.sv | 101 ++++++++++
 tb/tb_reorder_buffer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and entry type for the reorder buffer, the arch register
// file and the interface between them.
package reorder_buffer_pkg;

  localparam int NUM_ROB_ENTRIES = 16;
  localparam int RETIRE_WIDTH    = 2;
  localparam int NUM_FUS         = 3;
  localparam int NUM_AREGS       = 32;

  localparam int ROB_IDX_W = $clog2(NUM_ROB_ENTRIES);
  localparam int PTR_W     = ROB_IDX_W + 1;
  localparam int CNT_W     = $clog2(NUM_ROB_ENTRIES) + 1;
  localparam int AREG_W    = $clog2(NUM_AREGS);
  localparam int RET_CNT_W = $clog2(RETIRE_WIDTH + 1);

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              has_dst;
    logic [AREG_W-1:0] dst_reg;
    logic [31:0]       result;
  } rob_entry_t;

endpackage

// File: rtl/arch_reg_file_reorder_buffer_if.sv
// One retire write port from the reorder buffer into the arch register file.
interface arch_reg_file_reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic              valid;
  logic [AREG_W-1:0] dst_reg;
  logic [31:0]       result;

  modport rob (output valid, output dst_reg, output result);
  modport arf (input valid, input dst_reg, input result);

endinterface

// File: rtl/rob_retire_select.sv
// Picks the in-order retire prefix from the RETIRE_WIDTH entries at head.
module rob_retire_select
  import reorder_buffer_pkg::*;
(
  input  logic [RETIRE_WIDTH-1:0] busy,
  input  logic [RETIRE_WIDTH-1:0] done,
  output logic [RETIRE_WIDTH-1:0] retire_mask,
  output logic [RET_CNT_W-1:0]    retire_cnt
);

  // A slot retires only if every older slot in the window retires too.
  assign retire_mask[0] = busy[0] & done[0];
  for (genvar k = 1; k < RETIRE_WIDTH; k++) begin : g_prefix
    assign retire_mask[k] = retire_mask[k-1] & busy[k] & done[k];
  end

  // Population count of the prefix mask equals its length.
  always_comb begin
    retire_cnt = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      retire_cnt = retire_cnt + RET_CNT_W'(retire_mask[k]);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates at tail, collects out-of-order results,
// retires up to RETIRE_WIDTH completed entries per cycle from head.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic                 alloc_has_dst,
  input  logic [AREG_W-1:0]    alloc_dst_reg,
  output logic [ROB_IDX_W-1:0] alloc_tag,
  input  logic                 wb_valid  [NUM_FUS],
  input  logic [ROB_IDX_W-1:0] wb_tag    [NUM_FUS],
  input  logic [31:0]          wb_result [NUM_FUS],
  input  logic                 flush,
  arch_reg_file_reorder_buffer_if.rob rob_if [RETIRE_WIDTH],
  output logic [CNT_W-1:0]     count,
  output logic                 empty
);

  rob_entry_t entries [NUM_ROB_ENTRIES];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [ROB_IDX_W-1:0]    win_idx [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] win_busy;
  logic [RETIRE_WIDTH-1:0] win_done;
  logic [RETIRE_WIDTH-1:0] retire_mask;
  logic [RET_CNT_W-1:0]    retire_cnt;
  logic                    full;
  logic                    alloc_fire;

  // Same index with opposite wrap bits means every slot is occupied.
  assign full        = (head[ROB_IDX_W-1:0] == tail[ROB_IDX_W-1:0]) &&
                       (head[ROB_IDX_W] != tail[ROB_IDX_W]);
  assign count       = tail - head;
  assign empty       = (count == '0);
  assign alloc_ready = rst && !full;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail[ROB_IDX_W-1:0];

  for (genvar k = 0; k < RETIRE_WIDTH; k++) begin : g_window
    assign win_idx[k]  = head[ROB_IDX_W-1:0] + ROB_IDX_W'(k);
    assign win_busy[k] = entries[win_idx[k]].busy;
    assign win_done[k] = entries[win_idx[k]].done;

    // Entries without a real destination still retire but do not write.
    assign rob_if[k].valid   = rst && retire_mask[k] && entries[win_idx[k]].has_dst &&
                               (entries[win_idx[k]].dst_reg != '0);
    assign rob_if[k].dst_reg = entries[win_idx[k]].dst_reg;
    assign rob_if[k].result  = entries[win_idx[k]].result;
  end

  rob_retire_select u_retire_select (
    .busy        (win_busy),
    .done        (win_done),
    .retire_mask (retire_mask),
    .retire_cnt  (retire_cnt)
  );

  // Pointer and entry update: retire, then flush or writeback/allocate.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < NUM_ROB_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (retire_mask[k]) begin
          entries[win_idx[k]].busy <= 1'b0;
        end
      end
      if (flush) begin
        head <= '0;
        tail <= '0;
        for (int i = 0; i < NUM_ROB_ENTRIES; i++) begin
          entries[i].busy <= 1'b0;
          entries[i].done <= 1'b0;
        end
      end else begin
        head <= head + PTR_W'(retire_cnt);
        // Walk ports high to low so the lowest port's write lands last.
        for (int p = NUM_FUS - 1; p >= 0; p--) begin
          if (wb_valid[p] && entries[wb_tag[p]].busy) begin
            entries[wb_tag[p]].done   <= 1'b1;
            entries[wb_tag[p]].result <= wb_result[p];
          end
        end
        if (alloc_fire) begin
          entries[tail[ROB_IDX_W-1:0]] <= '{busy: 1'b1, done: 1'b0, has_dst: alloc_has_dst,
                                           dst_reg: alloc_dst_reg, result: 32'h0};
          tail <= tail + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a random
// run against a program-order queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic alloc_valid = 1'b0;
  logic alloc_ready;
  logic alloc_has_dst = 1'b0;
  logic [AREG_W-1:0] alloc_dst_reg = '0;
  logic [ROB_IDX_W-1:0] alloc_tag;
  logic wb_valid [NUM_FUS];
  logic [ROB_IDX_W-1:0] wb_tag [NUM_FUS];
  logic [31:0] wb_result [NUM_FUS];
  logic flush = 1'b0;
  logic [CNT_W-1:0] count;
  logic empty;

  arch_reg_file_reorder_buffer_if rob_if [RETIRE_WIDTH] ();

  logic              rv [RETIRE_WIDTH];
  logic [AREG_W-1:0] rd [RETIRE_WIDTH];
  logic [31:0]       rr [RETIRE_WIDTH];

  for (genvar k = 0; k < RETIRE_WIDTH; k++) begin : g_tap
    assign rv[k] = rob_if[k].valid;
    assign rd[k] = rob_if[k].dst_reg;
    assign rr[k] = rob_if[k].result;
  end

  reorder_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_has_dst (alloc_has_dst),
    .alloc_dst_reg (alloc_dst_reg),
    .alloc_tag     (alloc_tag),
    .wb_valid      (wb_valid),
    .wb_tag        (wb_tag),
    .wb_result     (wb_result),
    .flush         (flush),
    .rob_if        (rob_if),
    .count         (count),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: tags of live entries in program order plus per-tag fields.
  int q[$];
  int m_tail = 0;
  bit m_done [NUM_ROB_ENTRIES];
  bit m_hd [NUM_ROB_ENTRIES];
  int m_dst [NUM_ROB_ENTRIES];
  logic [31:0] m_res [NUM_ROB_ENTRIES];

  function automatic int m_ret_cnt();
    int r = 0;
    while (r < RETIRE_WIDTH && r < q.size() && m_done[q[r]]) r++;
    return r;
  endfunction

  function automatic bit m_busy(int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_exp_valid(int k);
    if (k >= m_ret_cnt()) return 1'b0;
    return m_hd[q[k]] && (m_dst[q[k]] != 0);
  endfunction

  // Advance the model with the current inputs, clock once, clear pulses.
  task automatic step();
    int r;
    int pre;
    int t;
    bit claimed [NUM_ROB_ENTRIES];
    claimed = '{default: 1'b0};
    pre = q.size();
    r = m_ret_cnt();
    if (!rst) begin
      q.delete();
      m_tail = 0;
    end else begin
      for (int p = 0; p < NUM_FUS; p++) begin
        t = int'(wb_tag[p]);
        if (wb_valid[p] && m_busy(t) && !claimed[t]) begin
          claimed[t] = 1'b1;
          m_done[t] = 1'b1;
          m_res[t] = wb_result[p];
        end
      end
      repeat (r) void'(q.pop_front());
      if (flush) begin
        q.delete();
        m_tail = 0;
      end else if (alloc_valid && pre < NUM_ROB_ENTRIES) begin
        t = m_tail % NUM_ROB_ENTRIES;
        m_done[t] = 1'b0;
        m_hd[t] = alloc_has_dst;
        m_dst[t] = int'(alloc_dst_reg);
        q.push_back(t);
        m_tail++;
      end
    end
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    flush = 1'b0;
    for (int p = 0; p < NUM_FUS; p++) wb_valid[p] = 1'b0;
  endtask

  task automatic do_alloc(input bit has, input int dst);
    alloc_valid = 1'b1;
    alloc_has_dst = has;
    alloc_dst_reg = AREG_W'(dst);
    step();
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] res);
    wb_valid[p] = 1'b1;
    wb_tag[p] = ROB_IDX_W'(tag);
    wb_result[p] = res;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL reset_alloc_ready got=%0b exp=0", alloc_ready); end
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      checks++; if (rv[k] !== 1'b0) begin failures++; $display("FAIL reset_valid%0d got=%0b exp=0", k, rv[k]); end
    end
    rst = 1'b1;
    #1;
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL release_alloc_ready got=%0b exp=1", alloc_ready); end
    checks++; if (count !== '0) begin failures++; $display("FAIL release_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL release_empty got=%0b exp=1", empty); end
    checks++; if (alloc_tag !== '0) begin failures++; $display("FAIL release_alloc_tag got=%0d exp=0", alloc_tag); end
  endtask

  task automatic test_in_order();
    do_alloc(1'b1, 5);
    do_alloc(1'b1, 6);
    do_alloc(1'b1, 7);
    checks++; if (count !== CNT_W'(3)) begin failures++; $display("FAIL inorder_count3 got=%0d exp=3", count); end
    set_wb(0, 0, 32'hA);
    set_wb(1, 1, 32'hB);
    set_wb(2, 2, 32'hC);
    step();
    checks++; if (rv[0] !== 1'b1 || rd[0] !== AREG_W'(5) || rr[0] !== 32'hA) begin failures++; $display("FAIL inorder_slot0 got=%0b/x%0d/%h exp=1/x5/a", rv[0], rd[0], rr[0]); end
    checks++; if (rv[1] !== 1'b1 || rd[1] !== AREG_W'(6) || rr[1] !== 32'hB) begin failures++; $display("FAIL inorder_slot1 got=%0b/x%0d/%h exp=1/x6/b", rv[1], rd[1], rr[1]); end
    step();
    checks++; if (count !== CNT_W'(1)) begin failures++; $display("FAIL inorder_count1 got=%0d exp=1", count); end
    checks++; if (rv[0] !== 1'b1 || rd[0] !== AREG_W'(7) || rr[0] !== 32'hC) begin failures++; $display("FAIL inorder_third got=%0b/x%0d/%h exp=1/x7/c", rv[0], rd[0], rr[0]); end
    checks++; if (rv[1] !== 1'b0) begin failures++; $display("FAIL inorder_slot1_idle got=%0b exp=0", rv[1]); end
    step();
    checks++; if (count !== '0 || empty !== 1'b1) begin failures++; $display("FAIL inorder_drained count=%0d empty=%0b exp=0/1", count, empty); end
  endtask

  task automatic test_out_of_order();
    int t0;
    t0 = m_tail % NUM_ROB_ENTRIES;
    do_alloc(1'b1, 10);
    do_alloc(1'b1, 11);
    set_wb(1, (t0 + 1) % NUM_ROB_ENTRIES, 32'h111);
    step();
    checks++; if (rv[0] !== 1'b0 || count !== CNT_W'(2)) begin failures++; $display("FAIL ooo_no_retire valid=%0b count=%0d exp=0/2", rv[0], count); end
    set_wb(0, t0, 32'h100);
    set_wb(2, t0, 32'hDEAD);
    step();
    checks++; if (rv[0] !== 1'b1 || rd[0] !== AREG_W'(10) || rr[0] !== 32'h100) begin failures++; $display("FAIL ooo_slot0_lowport got=%0b/x%0d/%h exp=1/x10/100", rv[0], rd[0], rr[0]); end
    checks++; if (rv[1] !== 1'b1 || rd[1] !== AREG_W'(11) || rr[1] !== 32'h111) begin failures++; $display("FAIL ooo_slot1 got=%0b/x%0d/%h exp=1/x11/111", rv[1], rd[1], rr[1]); end
    step();
    checks++; if (count !== '0) begin failures++; $display("FAIL ooo_drained got=%0d exp=0", count); end
  endtask

  task automatic test_no_dst();
    int t0;
    t0 = m_tail % NUM_ROB_ENTRIES;
    do_alloc(1'b0, 9);
    do_alloc(1'b1, 0);
    set_wb(0, t0, 32'h1);
    set_wb(1, (t0 + 1) % NUM_ROB_ENTRIES, 32'h2);
    step();
    checks++; if (rv[0] !== 1'b0 || rv[1] !== 1'b0) begin failures++; $display("FAIL nodst_valid got=%0b%0b exp=00", rv[0], rv[1]); end
    checks++; if (count !== CNT_W'(2)) begin failures++; $display("FAIL nodst_count_before got=%0d exp=2", count); end
    step();
    checks++; if (count !== '0) begin failures++; $display("FAIL nodst_count_after got=%0d exp=0", count); end
    t0 = m_tail % NUM_ROB_ENTRIES;
    do_alloc(1'b1, 3);
    set_wb(0, t0, 32'h33);
    step();
    checks++; if (rv[0] !== 1'b1 || rd[0] !== AREG_W'(3) || rr[0] !== 32'h33) begin failures++; $display("FAIL nodst_head_advanced got=%0b/x%0d/%h exp=1/x3/33", rv[0], rd[0], rr[0]); end
    step();
  endtask

  task automatic test_full_wrap();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < NUM_ROB_ENTRIES; i++) do_alloc(1'b1, (i % 31) + 1);
    checks++; if (count !== CNT_W'(NUM_ROB_ENTRIES) || alloc_ready !== 1'b0) begin failures++; $display("FAIL full_state count=%0d ready=%0b exp=16/0", count, alloc_ready); end
    alloc_valid = 1'b1;
    step();
    checks++; if (count !== CNT_W'(NUM_ROB_ENTRIES)) begin failures++; $display("FAIL full_no_alloc got=%0d exp=16", count); end
    set_wb(0, 0, 32'h50);
    set_wb(1, 1, 32'h51);
    step();
    checks++; if (rv[0] !== 1'b1 || rr[0] !== 32'h50 || rv[1] !== 1'b1 || rr[1] !== 32'h51) begin failures++; $display("FAIL full_retire got=%0b/%h %0b/%h exp=1/50 1/51", rv[0], rr[0], rv[1], rr[1]); end
    checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL full_ready_in_retire got=%0b exp=0", alloc_ready); end
    alloc_valid = 1'b1;
    step();
    checks++; if (count !== CNT_W'(14) || alloc_ready !== 1'b1) begin failures++; $display("FAIL full_after_retire count=%0d ready=%0b exp=14/1", count, alloc_ready); end
    checks++; if (alloc_tag !== '0) begin failures++; $display("FAIL full_wrap_tag got=%0d exp=0", alloc_tag); end
    flush = 1'b1;
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) do_alloc(1'b1, 12 + i);
    set_wb(0, 0, 32'h77);
    step();
    checks++; if (rv[0] !== 1'b1 || rd[0] !== AREG_W'(12) || rr[0] !== 32'h77) begin failures++; $display("FAIL flush_head_retire got=%0b/x%0d/%h exp=1/x12/77", rv[0], rd[0], rr[0]); end
    flush = 1'b1;
    alloc_valid = 1'b1;
    step();
    checks++; if (count !== '0 || empty !== 1'b1 || alloc_tag !== '0) begin failures++; $display("FAIL flush_cleared count=%0d empty=%0b tag=%0d exp=0/1/0", count, empty, alloc_tag); end
    set_wb(0, 2, 32'h99);
    step();
    checks++; if (rv[0] !== 1'b0 || count !== '0) begin failures++; $display("FAIL flush_stale_wb valid=%0b count=%0d exp=0/0", rv[0], count); end
    step();
    checks++; if (rv[0] !== 1'b0) begin failures++; $display("FAIL flush_stale_late got=%0b exp=0", rv[0]); end
  endtask

  task automatic test_random();
    bit ev;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      #1;
      checks++; if (alloc_ready !== (rst && q.size() < NUM_ROB_ENTRIES)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b", cyc, alloc_ready); end
      checks++; if (alloc_tag !== ROB_IDX_W'(m_tail % NUM_ROB_ENTRIES)) begin failures++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", cyc, alloc_tag, m_tail % NUM_ROB_ENTRIES); end
      checks++; if (count !== CNT_W'(q.size()) || empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d/%0b exp=%0d", cyc, count, empty, q.size()); end
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        ev = rst && m_exp_valid(k);
        checks++; if (rv[k] !== ev) begin failures++; $display("FAIL rnd_valid%0d cyc=%0d got=%0b exp=%0b", k, cyc, rv[k], ev); end
        if (ev) begin
          checks++; if (rd[k] !== AREG_W'(m_dst[q[k]]) || rr[k] !== m_res[q[k]]) begin failures++; $display("FAIL rnd_data%0d cyc=%0d got=x%0d/%h exp=x%0d/%h", k, cyc, rd[k], rr[k], m_dst[q[k]], m_res[q[k]]); end
        end
      end
      rst = ($urandom_range(0, 199) != 0);
      alloc_valid = ($urandom_range(0, 2) != 0);
      alloc_has_dst = ($urandom_range(0, 3) != 0);
      alloc_dst_reg = AREG_W'($urandom_range(0, NUM_AREGS - 1));
      for (int p = 0; p < NUM_FUS; p++) begin
        wb_valid[p] = $urandom_range(0, 1) != 0;
        if (q.size() > 0 && $urandom_range(0, 3) != 0) wb_tag[p] = ROB_IDX_W'(q[$urandom_range(0, q.size() - 1)]);
        else wb_tag[p] = ROB_IDX_W'($urandom_range(0, NUM_ROB_ENTRIES - 1));
        wb_result[p] = $urandom;
      end
      flush = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < NUM_FUS; p++) begin
      wb_valid[p] = 1'b0;
      wb_tag[p] = '0;
      wb_result[p] = '0;
    end
    test_reset();
    test_in_order();
    test_out_of_order();
    test_no_dst();
    test_full_wrap();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
